sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Arbitrates a single-port 32-bit external SRAM between the instruction-fetch port (`pc` / `IF_ID` path) and the data port of the `MEM` stage. It sequences each access as a fixed-length multi-cycle transaction through a small FSM and returns read data with a one-cycle `ready` pulse. It also raises a pipeline stall request while either port is waiting. It sits at the `CPU` top level between the pipeline and the SRAM pins, replacing the direct `romAddr_o` / `romData_i` link.

## Interface
- `WAIT_CYCLES`, default 2: SRAM access cycles per transaction; legal range 1–15.
- `ADDR_W`, default 20: SRAM word-address width.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `if_req_i`  in  1  fetch request; held until `if_ready_o`.
- `if_addr_i`  in  32  byte address of the fetch.
- `if_data_o`  out  32  fetched word; valid while `if_ready_o`=1.
- `if_ready_o`  out  1  one-cycle completion pulse for the fetch.
- `mem_req_i`  in  1  data request; held until `mem_ready_o`.
- `mem_we_i`  in  1  1 = write, 0 = read.
- `mem_sel_i`  in  4  byte enables, bit n selects byte lane n.
- `mem_addr_i`  in  32  byte address of the data access.
- `mem_wdata_i`  in  32  write data.
- `mem_rdata_o`  out  32  read data; valid while `mem_ready_o`=1.
- `mem_ready_o`  out  1  one-cycle completion pulse for the data access.
- `stall_req_o`  out  1  pipeline stall request.
- `sram_ce_n_o`  out  1  SRAM chip enable, active low.
- `sram_oe_n_o`  out  1  SRAM output enable, active low.
- `sram_we_n_o`  out  1  SRAM write enable, active low.
- `sram_be_n_o`  out  4  SRAM byte enables, active low.
- `sram_addr_o`  out  ADDR_W  SRAM word address.
- `sram_wdata_o`  out  32  data driven to SRAM.
- `sram_wdata_oe_o`  out  1  tristate enable for `sram_wdata_o`.
- `sram_rdata_i`  in  32  data from SRAM.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- Owner register `grant` records the served port: 0 = IF, 1 = MEM.
- Cycle counter `cnt` is 4 bits wide.

Transitions:
- IDLE → ACCESS when `mem_req_i` or `if_req_i` is high. MEM has fixed priority because it is the older instruction. On entry, latch `grant`, the address, `we`, `sel` and `wdata`, and set `cnt`=0.
- ACCESS: `cnt` increments each cycle. On the cycle with `cnt`=WAIT_CYCLES-1, `sram_rdata_i` is captured into the granted port's data register (reads and IF only), then the FSM goes to DONE.
- DONE: assert the granted port's `ready` for exactly one cycle, then go to IDLE unconditionally. No new grant is made in DONE.

SRAM pin behaviour in ACCESS:
- `sram_ce_n_o`=0.
- `sram_addr_o` = latched address bits [ADDR_W+1:2]; byte-address bits [1:0] are ignored.
- Read (or IF): `sram_oe_n_o`=0, `sram_we_n_o`=1, `sram_be_n_o`=4'b0000, `sram_wdata_oe_o`=0.
- Write: `sram_oe_n_o`=1, `sram_we_n_o`=0, `sram_be_n_o`=~sel, `sram_wdata_oe_o`=1, `sram_wdata_o` = latched wdata.

SRAM pin behaviour outside ACCESS:
- `ce_n`, `oe_n`, `we_n` = 1; `be_n`=4'b1111; `wdata_oe`=0; addr and wdata hold their last value.

Other rules:
- `stall_req_o` = (`if_req_i` & ~`if_ready_o`) | (`mem_req_i` & ~`mem_ready_o`). This is combinational and deasserts in the `ready` cycle, so the pipeline advances on that edge.
- `if_data_o` and `mem_rdata_o` hold their captured value until the next capture for the same port.
- A write never updates `mem_rdata_o`.
- Requests that drop while in ACCESS are still completed; the `ready` pulse is issued anyway.

## Timing
- Reset (`rst`=0 at an edge): next state IDLE. Reset values: `cnt`=0, `grant`=0, both `ready`=0, `if_data_o`=0, `mem_rdata_o`=0, `sram_addr_o`=0, `sram_wdata_o`=0, and all SRAM strobes inactive as listed above.
- Reset asserted mid-ACCESS aborts the transaction: no `ready` pulse, no data capture.
- Latency: a request sampled high in IDLE at edge k gives ACCESS in cycles k+1 .. k+WAIT_CYCLES and `ready` in cycle k+WAIT_CYCLES+1.
- Back-to-back throughput: one transaction per WAIT_CYCLES+2 cycles (includes one IDLE cycle).
- Simultaneous IF and MEM requests in IDLE: MEM is served first. IF is granted in the IDLE cycle after MEM's DONE. IF stall spans both transactions, 2·(WAIT_CYCLES+2) cycles at most.
- A requester sees its own `ready` only; the other port's `ready` stays 0.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with both requests high. Expect all outputs at reset values and no strobe activity. After release, MEM is granted first.
- **IF read, WAIT_CYCLES=2:** `if_req_i`=1, `if_addr_i`=0x0000_0010, SRAM word 4 = 0x2408_0005. Expect `sram_addr_o`=4 and `oe_n`=0 for 2 cycles, then `if_ready_o`=1 and `if_data_o`=0x2408_0005 in the 3rd cycle after the sample edge. `stall_req_o`=1 until then.
- **Byte write:** `mem_we_i`=1, `mem_sel_i`=4'b0010, `mem_addr_i`=0x0000_0104, `mem_wdata_i`=0xAABBCCDD. Expect `sram_be_n_o`=4'b1101, `we_n`=0, `wdata_oe`=1, addr=0x41, and `mem_rdata_o` unchanged. A read-back of word 0x41 shows only byte 1 = 0xCC changed.
- **Contention:** `if_req_i` and `mem_req_i` rise in the same cycle. Expect `mem_ready_o` at cycle +3 and `if_ready_o` at cycle +7. No cycle has both `ready` signals high.
- **Reset mid-access:** pull `rst`=0 during the 2nd ACCESS cycle. Expect no `ready` pulse, strobes inactive on the next cycle, and the read-data registers cleared to 0.
- **WAIT_CYCLES=1 back-to-back IF:** three consecutive fetches at 0x0, 0x4, 0x8. Expect `if_ready_o` pulses exactly 3 cycles apart with the correct words.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - single-port SRAM arbiter between instruction fetch and data ports
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_ready_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_ready_o,
    output logic              stall_req_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    output logic              sram_wdata_oe_o,
    input  logic [31:0]       sram_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic       grant;     // 0 = fetch port, 1 = data port
    logic       weReg;     // latched write flag of the granted access
    logic [3:0] cnt;

    // Byte-offset and high address bits never reach the word-addressed SRAM
    logic unusedAddrBits;
    assign unusedAddrBits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                              mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    // A port keeps the pipeline stalled until the cycle its ready pulse appears
    assign stall_req_o = (if_req_i & ~if_ready_o) | (mem_req_i & ~mem_ready_o);

    // Transaction sequencer; SRAM strobes are registered so they change only on state entry/exit
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            grant           <= 1'b0;
            weReg           <= 1'b0;
            if_ready_o      <= 1'b0;
            mem_ready_o     <= 1'b0;
            if_data_o       <= 32'd0;
            mem_rdata_o     <= 32'd0;
            sram_ce_n_o     <= 1'b1;
            sram_oe_n_o     <= 1'b1;
            sram_we_n_o     <= 1'b1;
            sram_be_n_o     <= 4'b1111;
            sram_wdata_oe_o <= 1'b0;
            sram_addr_o     <= '0;
            sram_wdata_o    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if_ready_o  <= 1'b0;
                    mem_ready_o <= 1'b0;
                    if (mem_req_i || if_req_i) begin
                        state       <= ACCESS;
                        cnt         <= 4'd0;
                        sram_ce_n_o <= 1'b0;
                        // The data port belongs to the older instruction, so it wins ties
                        if (mem_req_i) begin
                            grant       <= 1'b1;
                            weReg       <= mem_we_i;
                            sram_addr_o <= mem_addr_i[ADDR_W+1:2];
                            if (mem_we_i) begin
                                sram_oe_n_o     <= 1'b1;
                                sram_we_n_o     <= 1'b0;
                                sram_be_n_o     <= ~mem_sel_i;
                                sram_wdata_oe_o <= 1'b1;
                                sram_wdata_o    <= mem_wdata_i;
                            end else begin
                                sram_oe_n_o     <= 1'b0;
                                sram_we_n_o     <= 1'b1;
                                sram_be_n_o     <= 4'b0000;
                                sram_wdata_oe_o <= 1'b0;
                            end
                        end else begin
                            grant           <= 1'b0;
                            weReg           <= 1'b0;
                            sram_addr_o     <= if_addr_i[ADDR_W+1:2];
                            sram_oe_n_o     <= 1'b0;
                            sram_we_n_o     <= 1'b1;
                            sram_be_n_o     <= 4'b0000;
                            sram_wdata_oe_o <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT) begin
                        state           <= DONE;
                        sram_ce_n_o     <= 1'b1;
                        sram_oe_n_o     <= 1'b1;
                        sram_we_n_o     <= 1'b1;
                        sram_be_n_o     <= 4'b1111;
                        sram_wdata_oe_o <= 1'b0;
                        if (grant) begin
                            mem_ready_o <= 1'b1;
                            if (!weReg) begin
                                mem_rdata_o <= sram_rdata_i;
                            end
                        end else begin
                            if_ready_o <= 1'b1;
                            if_data_o  <= sram_rdata_i;
                        end
                    end
                end
                DONE: begin
                    // Ready lasts one cycle; arbitration resumes only from IDLE
                    if_ready_o  <= 1'b0;
                    mem_ready_o <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed vector bench for sram_arbiter
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ifReq, ifReady, memReq, memWe, memReady, stall;
    logic [31:0] ifAddr, ifData, memAddr, memWdata, memRdata;
    logic [3:0]  memSel, beN;
    logic        ceN, oeN, weN, wdataOe;
    logic [19:0] sramAddr;
    logic [31:0] sramWdata, sramRdata;

    logic        ifReq1, ifReady1, memReady1, stall1;
    logic [31:0] ifAddr1, ifData1, memRdata1;
    logic [3:0]  beN1;
    logic        ceN1, oeN1, weN1, wdataOe1;
    logic [19:0] sramAddr1;
    logic [31:0] sramWdata1, sramRdata1;

    sram_arbiter #(.WAIT_CYCLES(2), .ADDR_W(20)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(ifReq), .if_addr_i(ifAddr), .if_data_o(ifData), .if_ready_o(ifReady),
        .mem_req_i(memReq), .mem_we_i(memWe), .mem_sel_i(memSel), .mem_addr_i(memAddr),
        .mem_wdata_i(memWdata), .mem_rdata_o(memRdata), .mem_ready_o(memReady),
        .stall_req_o(stall), .sram_ce_n_o(ceN), .sram_oe_n_o(oeN), .sram_we_n_o(weN),
        .sram_be_n_o(beN), .sram_addr_o(sramAddr), .sram_wdata_o(sramWdata),
        .sram_wdata_oe_o(wdataOe), .sram_rdata_i(sramRdata)
    );

    sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(20)) dut1 (
        .clk(clk), .rst(rst),
        .if_req_i(ifReq1), .if_addr_i(ifAddr1), .if_data_o(ifData1), .if_ready_o(ifReady1),
        .mem_req_i(1'b0), .mem_we_i(1'b0), .mem_sel_i(4'b0000), .mem_addr_i(32'd0),
        .mem_wdata_i(32'd0), .mem_rdata_o(memRdata1), .mem_ready_o(memReady1),
        .stall_req_o(stall1), .sram_ce_n_o(ceN1), .sram_oe_n_o(oeN1), .sram_we_n_o(weN1),
        .sram_be_n_o(beN1), .sram_addr_o(sramAddr1), .sram_wdata_o(sramWdata1),
        .sram_wdata_oe_o(wdataOe1), .sram_rdata_i(sramRdata1)
    );

    // Asynchronous-read SRAM model shared by both instances; only dut writes it
    logic [31:0] sram [0:255];
    assign sramRdata  = sram[sramAddr[7:0]];
    assign sramRdata1 = sram[sramAddr1[7:0]];

    always @(posedge clk) begin
        if (!rst) begin
            sram[0]     <= 32'h0000_0013;
            sram[1]     <= 32'h0040_0093;
            sram[4]     <= 32'h2408_0005;
            sram[8]     <= 32'hCAFE_F00D;
            sram[8'h41] <= 32'h1122_3344;
        end else if (!ceN && !weN) begin
            for (int b = 0; b < 4; b++) begin
                if (!beN[b]) sram[sramAddr[7:0]][8*b +: 8] <= sramWdata[8*b +: 8];
            end
        end
    end

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        isMem;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [19:0] expAddr;
        logic [3:0]  expBeN;
        logic [31:0] expData;   // port read register after the ready pulse
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] fetchAddr1 [3];
    logic [31:0] fetchData1 [3];

    task automatic runTxn(input vec_t v);
        int lat;
        @(negedge clk);
        memWe    = v.we;
        memSel   = v.sel;
        memAddr  = v.addr;
        memWdata = v.wdata;
        ifAddr   = v.addr;
        if (v.isMem) memReq = 1'b1; else ifReq = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("access ce_n", ceN, 0);
        check("access oe_n", oeN, v.we);
        check("access we_n", weN, !v.we);
        check("access be_n", beN, v.expBeN);
        check("access addr", sramAddr, v.expAddr);
        check("access wdata_oe", wdataOe, v.we);
        if (v.we) check("access wdata", sramWdata, v.wdata);
        check("access stall", stall, 1);
        lat = 1;
        while (!(v.isMem ? memReady : ifReady) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 3);
        if (v.isMem) begin
            check("mem rdata", memRdata, v.expData);
            check("if ready quiet", ifReady, 0);
        end else begin
            check("if data", ifData, v.expData);
            check("mem ready quiet", memReady, 0);
        end
        check("ready stall", stall, 0);
        memReq = 1'b0;
        ifReq  = 1'b0;
        @(negedge clk);
        check("idle ce_n", ceN, 1);
        check("idle ready", {30'd0, ifReady, memReady}, 0);
    endtask

    initial begin
        int memCyc, ifCyc, cyc, idx, lastCyc;
        logic bothHigh;

        vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h10,  32'h0,         20'h4,  4'b0000, 32'h2408_0005};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0,   32'h0,         20'h0,  4'b0000, 32'h0000_0013};
        vecs[2] = '{1'b1, 1'b1, 4'h2, 32'h104, 32'hAABB_CCDD, 20'h41, 4'b1101, 32'h0000_0013};
        vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h104, 32'h0,         20'h41, 4'b0000, 32'h1122_CC44};
        vecs[4] = '{1'b1, 1'b1, 4'hF, 32'h8,   32'hDEAD_BEEF, 20'h2,  4'b0000, 32'h1122_CC44};
        vecs[5] = '{1'b0, 1'b0, 4'hF, 32'h8,   32'h0,         20'h2,  4'b0000, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 1'b0, 4'hF, 32'h13,  32'h0,         20'h4,  4'b0000, 32'h2408_0005};
        fetchAddr1[0] = 32'h0; fetchAddr1[1] = 32'h4; fetchAddr1[2] = 32'h8;
        fetchData1[0] = 32'h0000_0013; fetchData1[1] = 32'h0040_0093; fetchData1[2] = 32'hDEAD_BEEF;

        // Reset with both requests pending
        rst = 1'b0;
        ifReq = 1'b1; ifAddr = 32'h10;
        memReq = 1'b1; memWe = 1'b0; memSel = 4'hF; memAddr = 32'h20; memWdata = 32'h0;
        ifReq1 = 1'b0; ifAddr1 = 32'h0;
        repeat (3) begin
            @(negedge clk);
            check("rst ready", {30'd0, ifReady, memReady}, 0);
            check("rst strobes", {27'd0, ceN, oeN, weN, wdataOe, 1'b0}, 32'b11100);
            check("rst be_n", beN, 4'b1111);
            check("rst addr", sramAddr, 0);
            check("rst wdata", sramWdata, 0);
            check("rst read regs", ifData | memRdata, 0);
        end

        // Contention right after reset release: MEM first, IF follows
        rst = 1'b1;
        memCyc = 0; ifCyc = 0; bothHigh = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) check("contention grants mem", sramAddr, 20'h8);
            if (c == 3) check("contention stall during mem ready", stall, 1);
            if (c == 7) check("contention stall during if ready", stall, 0);
            if (ifReady && memReady) bothHigh = 1'b1;
            if (memReady) begin memCyc = c; memReq = 1'b0; end
            if (ifReady)  begin ifCyc = c;  ifReq = 1'b0; end
        end
        check("contention mem ready cycle", memCyc, 3);
        check("contention if ready cycle", ifCyc, 7);
        check("contention both ready", {31'd0, bothHigh}, 0);
        check("contention mem data", memRdata, 32'hCAFE_F00D);
        check("contention if data", ifData, 32'h2408_0005);

        for (int i = 0; i < 7; i++) runTxn(vecs[i]);

        // Reset during the second ACCESS cycle
        @(negedge clk);
        memWe = 1'b0; memAddr = 32'h4; memReq = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        memReq = 1'b0;
        check("abort ready", memReady, 0);
        check("abort ce_n/oe_n", {30'd0, ceN, oeN}, 3);
        check("abort mem rdata", memRdata, 0);
        check("abort if data", ifData, 0);
        @(negedge clk);
        check("abort ready later", memReady, 0);
        rst = 1'b1;

        // WAIT_CYCLES=1 back-to-back fetches
        @(negedge clk);
        ifAddr1 = fetchAddr1[0];
        ifReq1  = 1'b1;
        cyc = 0; idx = 0; lastCyc = 0;
        while (idx < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ifReady1) begin
                check("b2b data", ifData1, fetchData1[idx]);
                if (idx == 0) check("b2b first latency", cyc, 2);
                else          check("b2b spacing", cyc - lastCyc, 3);
                lastCyc = cyc;
                idx++;
                if (idx < 3) ifAddr1 = fetchAddr1[idx];
                else         ifReq1 = 1'b0;
            end
        end
        check("b2b fetch count", idx, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
